// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state type and sizing helper for the multicycle adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational ripple-carry adder over one CHUNK-bit slice
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // carry into the slice MSB feeds signed-overflow detection on the last chunk
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - add/subtract processed CHUNK bits per cycle with valid/ready handshakes
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;

  int               base;
  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
  logic             ch_msb;
  logic             last;

  always_comb begin
    base = int'(cnt) * CHUNK;
    last = (cnt == CW'(N - 1));
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a       (op_a[base +: CHUNK]),
    .b       (op_b[base +: CHUNK]),
    .cin     (carry),
    .s       (ch_s),
    .cout    (ch_cout),
    .c_msb_in(ch_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // subtraction is a + ~b + 1, so cin is irrelevant in that mode
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sum_q[base +: CHUNK] <= ch_s;
          carry                <= ch_cout;
          if (last) begin
            cout_q <= ch_cout;
            ovf_q  <= ch_msb ^ ch_cout;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
